// File: rtl/dma_copy_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dma_pkg
// Shared widths, types and FSM state encoding for the single-channel
// copy controller (dma_copy_ctrl) and its memory request interface.
//   ADDR_W : memory address width (addresses wrap modulo 2^ADDR_W)
//   DATA_W : memory word width
//   LEN_W  : transfer length width, one bit wider so a full-memory copy fits
// ----------------------------------------------------------------------------
package dma_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LEN_W  = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [LEN_W-1:0]  len_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dma_copy_ctrl_if.sv
// ----------------------------------------------------------------------------
// dma_copy_ctrl_if
// Memory request port between the copy controller (master) and the on-chip
// memory (slave).
//   mem_ren   : read enable               (master -> slave)
//   mem_wen   : write enable              (master -> slave)
//   mem_addr  : address                   (master -> slave)
//   mem_wdata : write data                (master -> slave)
//   mem_rdata : read data, combinational  (slave -> master)
//   mem_ready : current ren/wen accepted  (slave -> master)
// ----------------------------------------------------------------------------
interface dma_copy_ctrl_if;
    import dma_pkg::*;

    logic  mem_ren;
    logic  mem_wen;
    addr_t mem_addr;
    word_t mem_wdata;
    word_t mem_rdata;
    logic  mem_ready;

    modport master (
        output mem_ren,
        output mem_wen,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_ren,
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/dma_copy_ctrl.sv
// ----------------------------------------------------------------------------
// dma_copy_ctrl
// Single-channel byte copy engine. On start it latches src/dst/length and
// moves the block one byte at a time: a READ cycle then a WRITE cycle per
// byte, each waiting for mem_ready. Addresses wrap modulo 2^ADDR_W and the
// copy is strictly forward (no overlap protection).
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   start               : begin a transfer (sampled only in IDLE)
//   abort               : cancel an in-flight transfer
//   src_addr, dst_addr  : first source / destination address
//   length              : byte count (0 is legal)
//   busy                : high while in READ or WRITE
//   done / aborted      : one-cycle completion pulses
//   count               : bytes written in the current/last transfer
//   mem                 : memory request port (master side)
// ----------------------------------------------------------------------------
module dma_copy_ctrl
    import dma_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  start,
    input  logic  abort,
    input  addr_t src_addr,
    input  addr_t dst_addr,
    input  len_t  length,
    output logic  busy,
    output logic  done,
    output logic  aborted,
    output len_t  count,
    dma_copy_ctrl_if.master mem
);

    dma_state_t state_q;
    addr_t      src_q, dst_q, addr_q;
    len_t       rem_q, count_q;
    word_t      buf_q;
    logic       busy_q, done_q, aborted_q, ren_q, wen_q;

    addr_t      src_d, dst_d;

    assign src_d = src_q + addr_t'(1);
    assign dst_d = dst_q + addr_t'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            buf_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
        end else begin
            // Pulse outputs default low so each lasts exactly one cycle.
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q   <= src_addr;
                        dst_q   <= dst_addr;
                        rem_q   <= length;
                        count_q <= '0;
                        if (length == '0) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= READ;
                            busy_q  <= 1'b1;
                            ren_q   <= 1'b1;
                            addr_q  <= src_addr;
                        end
                    end
                end
                READ: begin
                    // Abort takes priority over a ready handshake.
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        ren_q     <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (mem.mem_ready) begin
                        buf_q   <= mem.mem_rdata;
                        src_q   <= src_d;
                        state_q <= WRITE;
                        ren_q   <= 1'b0;
                        wen_q   <= 1'b1;
                        addr_q  <= dst_q;
                    end
                end
                WRITE: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        wen_q     <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (mem.mem_ready) begin
                        dst_q   <= dst_d;
                        count_q <= count_q + len_t'(1);
                        rem_q   <= rem_q - len_t'(1);
                        wen_q   <= 1'b0;
                        if (rem_q == len_t'(1)) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            // src_q already advanced during the READ handshake.
                            state_q <= READ;
                            ren_q   <= 1'b1;
                            addr_q  <= src_q;
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Abort gates the enables in the same cycle so an aborted WRITE never
    // reaches memory; the enables are only ever set in READ/WRITE.
    assign mem.mem_ren   = ren_q & ~abort;
    assign mem.mem_wen   = wen_q & ~abort;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = buf_q;

    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;
    assign count   = count_q;

endmodule

// File: doc/dma_copy_ctrl.md
Name: dma_copy_ctrl

Overview:
Single-channel copy controller that moves a block of bytes from a source region to a destination region of the 256×8 on-chip memory.
It sequences one read and then one write per byte over the memory request port, and honours the ready handshake.
It sits between the host/testbench control registers and the memory response side, and is the master on the memory port.

Parameters:
ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
DATA_W, 8, memory word width
LEN_W, ADDR_W+1, transfer-length width; allows a full 256-byte copy

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
start  in  1  begin a transfer; sampled only in IDLE
abort  in  1  cancel an in-flight transfer
src_addr  in  ADDR_W  first source address; latched on start
dst_addr  in  ADDR_W  first destination address; latched on start
length  in  LEN_W  byte count; latched on start; 0 is legal
busy  out  1  high from the cycle after start until completion or abort
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort completion
count  out  LEN_W  bytes written so far in the current/last transfer
mem_ren  out  1  memory read enable
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; combinational, valid while mem_ren=1
mem_ready  in  1  memory accepts the current ren/wen this cycle

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE; busy, done, aborted, mem_ren, mem_wen = 0; mem_addr, mem_wdata, count, internal src/dst/remaining/data-buffer registers = 0.
- States: IDLE, READ, WRITE, FINISH.
- IDLE:
  - start=1 latches src, dst and length, and clears count.
  - If length==0, go to FINISH. Otherwise go to READ.
  - Nothing is latched while start=0.
- READ:
  - Drive mem_ren=1 and mem_addr=src.
  - When mem_ready=1, capture mem_rdata into the buffer, increment src (wraps), and go to WRITE.
  - When mem_ready=0, hold all outputs unchanged.
- WRITE:
  - Drive mem_wen=1, mem_addr=dst and mem_wdata=buffer.
  - When mem_ready=1, increment dst (wraps), increment count and decrement remaining.
  - If remaining was 1, go to FINISH. Otherwise go to READ.
- FINISH: done=1 for exactly one cycle, busy=0, then return to IDLE.
- busy=1 in READ and WRITE; otherwise 0.
- mem_ren and mem_wen are never both 1. Both are 0 in IDLE and FINISH.
- Latency with ready always high:
  - 2 cycles per byte.
  - done is asserted 2·length+1 cycles after the start edge.
  - For length==0, done is asserted 1 cycle after the start edge.
- start while busy or in FINISH is ignored; the latched parameters are unchanged.
- Abort:
  - In READ or WRITE, abort=1 combinationally forces mem_ren=0 and mem_wen=0 that cycle, so no memory write occurs.
  - The next state is IDLE; aborted pulses for one cycle on that transition; count holds the bytes fully written.
  - In IDLE or FINISH, abort is ignored.
  - If abort and mem_ready are both high in WRITE, abort wins and the byte is not counted.
- Wrap-around: src and dst increment modulo 2^ADDR_W. length=256 copies the whole memory.
- Overlap: regions are copied strictly forward, one byte at a time, with no overlap protection. Results for overlapping regions with dst>src follow the forward byte order.
- RST mid-transfer: returns to IDLE with all outputs at reset values, no done and no aborted pulse. Memory contents are owned by the memory block.

Decomposition:
- Shared package dma_pkg holds:
  - ADDR_W, DATA_W and LEN_W defaults;
  - typedefs addr_t, word_t and len_t;
  - enum dma_state_t {IDLE, READ, WRITE, FINISH}.
- No sub-module; a single FSM plus datapath registers.
- Top-level integration binds the mem_* signals to the request side of the existing memory interface.

Test Plan:
- Basic copy: preload mem[0x10..0x13]=A1,A2,A3,A4; start with src=0x10, dst=0x80, len=4 -> mem[0x80..0x83]=A1..A4, done pulses 9 cycles after start, count=4, busy high for 8 cycles.
- Zero length: start with len=0 -> done pulses the next cycle; mem_ren/mem_wen never asserted; count=0.
- Wrap-around: preload mem[0xFE],[0xFF],[0x00]=11,22,33; start with src=0xFE, dst=0x40, len=3 -> mem[0x40..0x42]=11,22,33; read addresses observed FE,FF,00.
- Ready stall: hold mem_ready=0 for 3 cycles during the 2nd READ of a len=2 copy -> mem_addr and mem_ren stable throughout the stall, data correct, done at cycle 5+3=8.
- Abort: start a len=6 copy and assert abort in the 3rd byte's READ -> only dst, dst+1 written; aborted pulses; count=2; busy low the next cycle; no done.
- Ignored start: pulse start with different src/dst mid-transfer -> the original transfer completes unchanged. Then a len=256 full copy into a prefilled mirror -> count=256 and done after 513 cycles.
